// File: rtl/pulse_sequencer_if.sv
// ---------------------------------------------------------------------------
// pulse_sequencer_if
//
// Purpose: groups the control, configuration and status signals of the
// pulse_sequencer into one bundle. The upstream controller and output_reg
// side use the master modport; the sequencer itself uses the slave modport.
//
// Signals (direction as seen from the slave / sequencer):
//   start          in   1   one-cycle burst request (honoured only in IDLE)
//   abort          in   1   level, stops an active burst
//   t_period       in  16   repetition interval in us
//   t_impulse      in  10   impulse length in us
//   n_pulses       in   8   pulses per burst, 0 = continuous
//   out_reg_ready  in   1   output_reg can accept a new impulse
//   sign_start_gen out  1   one-cycle launch strobe to noise_generator
//   t_impulse_out  out 10   latched impulse length, stable for the burst
//   pulse_cnt      out  8   strobes issued in the current burst
//   busy           out  1   sequencer is not idle
//   done           out  1   one-cycle pulse on normal burst completion
//   error          out  1   sticky configuration-error flag
// ---------------------------------------------------------------------------
interface pulse_sequencer_if;
  logic        start;
  logic        abort;
  logic [15:0] t_period;
  logic [9:0]  t_impulse;
  logic [7:0]  n_pulses;
  logic        out_reg_ready;
  logic        sign_start_gen;
  logic [9:0]  t_impulse_out;
  logic [7:0]  pulse_cnt;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, abort, t_period, t_impulse, n_pulses, out_reg_ready,
    input  sign_start_gen, t_impulse_out, pulse_cnt, busy, done, error
  );

  modport slave (
    input  start, abort, t_period, t_impulse, n_pulses, out_reg_ready,
    output sign_start_gen, t_impulse_out, pulse_cnt, busy, done, error
  );
endinterface

// File: rtl/pulse_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_sequencer
//
// Purpose: upstream control stage of the noise synthesis chain. Emits a burst
// of launch strobes (sign_start_gen) to noise_generator, spaced by a
// programmable repetition interval, each strobe gated by out_reg_ready so the
// output register is never overrun. Holds a stable copy of the impulse length.
//
// Parameters:
//   CLK_PER_US  clock cycles per microsecond (legal range 1..1023)
//
// Ports:
//   clk_i   in  1   system clock, rising edge
//   rst_i   in  1   asynchronous active-high reset
//   bus     slave modport of pulse_sequencer_if (control, config, status)
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module pulse_sequencer #(
  parameter int unsigned CLK_PER_US = 500
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pulse_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    PERIOD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;          // cycles since the last strobe
  logic [31:0] limit_q, limit_d;      // interval length in clock cycles
  logic [7:0]  n_pulses_q, n_pulses_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic [9:0]  t_imp_q, t_imp_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;

  logic        cfg_ok;
  logic        period_end;
  logic        last_pulse;
  logic [31:0] limit_calc;

  // The impulse must be non-empty and fit strictly inside one interval.
  assign cfg_ok     = (bus.t_impulse != 10'd0) &&
                      ({6'd0, bus.t_impulse} < bus.t_period);
  // Product of a 16-bit and a 10-bit value always fits in 32 bits.
  assign limit_calc = {16'd0, bus.t_period} * 32'(CLK_PER_US);
  // A valid configuration guarantees limit_q >= 2, so L-1 never underflows
  // while a burst is active.
  assign period_end = (cnt_q == limit_q - 32'd1);
  assign last_pulse = (n_pulses_q != 8'd0) && (pulse_cnt_q == n_pulses_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      limit_q     <= '0;
      n_pulses_q  <= '0;
      pulse_cnt_q <= '0;
      t_imp_q     <= '0;
      sign_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      n_pulses_q  <= n_pulses_d;
      pulse_cnt_q <= pulse_cnt_d;
      t_imp_q     <= t_imp_d;
      sign_q      <= sign_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    n_pulses_d  = n_pulses_q;
    pulse_cnt_d = pulse_cnt_q;
    t_imp_d     = t_imp_q;
    sign_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        // abort suppresses a simultaneous start entirely (no error update).
        if (bus.start && !bus.abort) begin
          if (cfg_ok) begin
            limit_d     = limit_calc;
            t_imp_d     = bus.t_impulse;
            n_pulses_d  = bus.n_pulses;
            pulse_cnt_d = '0;
            error_d     = 1'b0;
            state_d     = WAIT_READY;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      WAIT_READY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.out_reg_ready) begin
          sign_d      = 1'b1;
          pulse_cnt_d = pulse_cnt_q + 8'd1;
          cnt_d       = '0;
          state_d     = PERIOD;
        end
      end

      PERIOD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (period_end) begin
            if (last_pulse) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (bus.out_reg_ready) begin
              // Back-to-back strobe keeps the spacing at exactly L cycles.
              sign_d      = 1'b1;
              pulse_cnt_d = pulse_cnt_q + 8'd1;
              cnt_d       = '0;
            end else begin
              // Slip: the next interval restarts from the late strobe.
              state_d = WAIT_READY;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.sign_start_gen = sign_q;
  assign bus.t_impulse_out  = t_imp_q;
  assign bus.pulse_cnt      = pulse_cnt_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pulse_sequencer
//
// Bench for pulse_sequencer with CLK_PER_US = 4. A time-based reference
// model predicts every output after each rising edge: a burst is described by
// the edge at which the next strobe becomes due, the strobe fires on the first
// edge at or after that time where out_reg_ready is high, and completion is
// decided on the due edge after the last strobe. A compare process checks all
// outputs against the model on every falling edge; directed tests add
// hand-computed literal expectations on strobe spacing, counts and flags.
// ---------------------------------------------------------------------------
module tb_pulse_sequencer;

  localparam int CPU = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  pulse_sequencer_if bus ();

  pulse_sequencer #(.CLK_PER_US(CPU)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", nm, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------------ model -----
  bit       m_active, m_sign, m_done, m_err;
  bit [7:0] m_pcnt, m_n;
  bit [9:0] m_timp;
  longint   m_edge, m_due, m_len;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_sign = 0; m_done = 0; m_err = 0;
      m_pcnt = 0; m_n = 0; m_timp = 0; m_edge = 0; m_due = 0; m_len = 0;
    end else begin
      m_edge++;
      m_sign = 0;
      m_done = 0;
      if (!m_active) begin
        if (bus.start && !bus.abort) begin
          if (bus.t_impulse != 0 && int'(bus.t_impulse) < int'(bus.t_period)) begin
            m_active = 1;
            m_len  = longint'(bus.t_period) * CPU;
            m_timp = bus.t_impulse;
            m_n    = bus.n_pulses;
            m_pcnt = 0;
            m_err  = 0;
            m_due  = m_edge + 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (bus.abort) begin
        m_active = 0;
      end else if (m_edge >= m_due) begin
        if (m_n != 0 && m_pcnt == m_n) begin
          m_done   = 1;
          m_active = 0;
        end else if (bus.out_reg_ready) begin
          m_sign = 1;
          m_pcnt = m_pcnt + 8'd1;
          m_due  = m_edge + m_len;
        end
      end
    end
  end

  // ------------------------------------------------- compare + logging ----
  int strobe_cyc[$];
  int strobe_cnt[$];
  int done_cyc[$];

  always @(negedge clk) begin
    chk("sign_start_gen", bus.sign_start_gen, m_sign);
    chk("done", bus.done, m_done);
    chk("busy", bus.busy, m_active);
    chk("error", bus.error, m_err);
    chk("pulse_cnt", bus.pulse_cnt, m_pcnt);
    chk("t_impulse_out", bus.t_impulse_out, m_timp);
    chk("sign_and_done_exclusive", bus.sign_start_gen && bus.done, 0);
    if (bus.sign_start_gen) begin
      strobe_cyc.push_back(cyc);
      strobe_cnt.push_back(int'(bus.pulse_cnt));
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  // ------------------------------------------------------- helpers --------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_logs();
    strobe_cyc.delete();
    strobe_cnt.delete();
    done_cyc.delete();
  endtask

  function automatic int sc(input int i);
    return (i < strobe_cyc.size()) ? strobe_cyc[i] : -1;
  endfunction

  function automatic int sn(input int i);
    return (i < strobe_cnt.size()) ? strobe_cnt[i] : -1;
  endfunction

  function automatic int dc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  task automatic start_burst(input int tp, input int ti, input int np, output int t0);
    tick();
    bus.t_period  = 16'(tp);
    bus.t_impulse = 10'(ti);
    bus.n_pulses  = 8'(np);
    bus.start     = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      tick();
      k++;
    end
    chk(nm, bus.done, 1);
  endtask

  task automatic wait_strobes(input string nm, input int n, input int budget);
    int k = 0;
    while (strobe_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, strobe_cyc.size() >= n, 1);
  endtask

  // ------------------------------------------------------- stimulus -------
  initial begin
    int t0, s1, p, ns, bad;
    bus.start = 0; bus.abort = 0; bus.t_period = 0; bus.t_impulse = 0;
    bus.n_pulses = 0; bus.out_reg_ready = 1;

    // Reset state
    repeat (3) tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_pulse_cnt", bus.pulse_cnt, 0);
    chk("reset_error", bus.error, 0);
    rst = 0;
    tick();

    // Finite burst, ready always high: 3 strobes, 12 cycles apart
    clr_logs();
    start_burst(3, 2, 3, t0);
    wait_done("t1_done_timeout", 200);
    $display("t1: strobes=%0d done_cyc=%0d", strobe_cyc.size(), dc(0));
    chk("t1_num_strobes", strobe_cyc.size(), 3);
    chk("t1_first_latency", sc(0) - t0, 2);
    chk("t1_gap1", sc(1) - sc(0), 12);
    chk("t1_gap2", sc(2) - sc(1), 12);
    chk("t1_cnt1", sn(0), 1);
    chk("t1_cnt2", sn(1), 2);
    chk("t1_cnt3", sn(2), 3);
    chk("t1_done_delay", dc(0) - sc(2), 12);
    chk("t1_busy_with_done", bus.busy, 0);
    chk("t1_t_impulse_out", bus.t_impulse_out, 2);
    tick();
    chk("t1_done_one_cycle", bus.done, 0);

    // Ready dropped for 5 cycles around the second strobe
    clr_logs();
    start_burst(3, 2, 3, t0);
    wait_strobes("t2_first_strobe_timeout", 1, 50);
    s1 = sc(0);
    while (cyc < s1 + 11) tick();
    bus.out_reg_ready = 0;
    repeat (5) tick();
    bus.out_reg_ready = 1;
    wait_done("t2_done_timeout", 200);
    $display("t2: strobes at %0d %0d %0d done %0d", sc(0), sc(1), sc(2), dc(0));
    chk("t2_gap_slipped", sc(1) - sc(0), 17);
    chk("t2_gap_after_slip", sc(2) - sc(1), 12);
    chk("t2_done_delay", dc(0) - sc(2), 12);

    // Invalid configurations, then recovery
    clr_logs();
    start_burst(5, 5, 3, t0);
    $display("t3: impulse==period -> error=%0d busy=%0d", bus.error, bus.busy);
    chk("t3_error_eq", bus.error, 1);
    chk("t3_busy_eq", bus.busy, 0);
    repeat (20) tick();
    chk("t3_no_strobe", strobe_cyc.size(), 0);
    start_burst(5, 0, 1, t0);
    chk("t3_error_zero_impulse", bus.error, 1);
    start_burst(3, 2, 1, t0);
    chk("t3_error_cleared", bus.error, 0);
    chk("t3_busy_valid", bus.busy, 1);
    wait_done("t3_done_timeout", 100);
    chk("t3_one_strobe", strobe_cyc.size(), 1);

    // Continuous mode: 300 strobes, wrap, then abort
    clr_logs();
    start_burst(2, 1, 0, t0);
    wait_strobes("t4_strobes_timeout", 300, 3000);
    bus.abort = 1;
    p  = int'(bus.pulse_cnt);
    ns = strobe_cyc.size();
    tick();
    bus.abort = 0;
    chk("t4_abort_busy", bus.busy, 0);
    bad = 0;
    for (int i = 1; i < 300; i++) if (sc(i) - sc(i-1) != 8) bad++;
    $display("t4: strobes=%0d bad_gaps=%0d cnt255=%0d cnt256=%0d cnt300=%0d",
             ns, bad, sn(254), sn(255), sn(299));
    chk("t4_bad_gaps", bad, 0);
    chk("t4_cnt_255", sn(254), 255);
    chk("t4_cnt_wrap", sn(255), 0);
    chk("t4_cnt_300", sn(299), 44);
    repeat (30) tick();
    chk("t4_no_strobe_after_abort", strobe_cyc.size(), ns);
    chk("t4_cnt_held", bus.pulse_cnt, p);
    chk("t4_no_done", done_cyc.size(), 0);

    // Start during burst ignored; abort+start in idle ignored
    clr_logs();
    start_burst(3, 2, 2, t0);
    wait_strobes("t5_first_strobe_timeout", 1, 50);
    bus.t_period = 7; bus.t_impulse = 3; bus.n_pulses = 9; bus.start = 1;
    tick();
    bus.start = 0;
    wait_done("t5_done_timeout", 100);
    chk("t5_strobes", strobe_cyc.size(), 2);
    chk("t5_gap", sc(1) - sc(0), 12);
    chk("t5_timp_kept", bus.t_impulse_out, 2);
    tick();
    bus.t_period = 4; bus.t_impulse = 1; bus.n_pulses = 1;
    bus.abort = 1; bus.start = 1;
    tick();
    bus.abort = 0; bus.start = 0;
    repeat (3) tick();
    $display("t5: idle abort+start -> busy=%0d cnt=%0d timp=%0d", bus.busy, bus.pulse_cnt, bus.t_impulse_out);
    chk("t5_abort_start_busy", bus.busy, 0);
    chk("t5_abort_start_cnt", bus.pulse_cnt, 2);
    chk("t5_abort_start_timp", bus.t_impulse_out, 2);

    // Asynchronous reset mid-interval
    clr_logs();
    start_burst(3, 2, 3, t0);
    wait_strobes("t6_first_strobe_timeout", 1, 50);
    repeat (5) tick();
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    $display("t6: async reset -> busy=%0d cnt=%0d timp=%0d", bus.busy, bus.pulse_cnt, bus.t_impulse_out);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_cnt", bus.pulse_cnt, 0);
    chk("t6_rst_timp", bus.t_impulse_out, 0);
    chk("t6_rst_sign", bus.sign_start_gen, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_error", bus.error, 0);
    tick();
    tick();
    rst = 0;
    repeat (3) tick();
    chk("t6_no_done", done_cyc.size(), 0);
    clr_logs();
    start_burst(3, 2, 1, t0);
    wait_done("t6_done_timeout", 100);
    chk("t6_restart_strobes", strobe_cyc.size(), 1);
    chk("t6_restart_latency", sc(0) - t0, 2);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
